regfile_wr_arbiter: RTL and testbench



---
 rtl/regfile_wr_arbiter_if.sv | 39 +++
 rtl/regfile_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bundle between the two writeback sources, the reservation port and the register file.
// The arbiter side (slave) consumes requests and reservations and produces grants, the write port and busy.
// The driver side (master) is the writeback/issue logic, or a testbench standing in for it.
interface regfile_wr_arbiter_if;
   // Requester A: main pipeline writeback
   logic        a_req;
   logic [4:0]  a_wn;
   logic [31:0] a_d;
   logic        a_gnt;
   // Requester B: long-latency unit writeback
   logic        b_req;
   logic [4:0]  b_wn;
   logic [31:0] b_d;
   logic        b_gnt;
   // Reservation from issue for a future B write
   logic        rsv_req;
   logic [4:0]  rsv_wn;
   // Register file write port and scoreboard
   logic        rf_we;
   logic [4:0]  rf_wn;
   logic [31:0] rf_d;
   logic [31:0] busy;

   modport master (
      output a_req, a_wn, a_d,
      output b_req, b_wn, b_d,
      output rsv_req, rsv_wn,
      input  a_gnt, b_gnt,
      input  rf_we, rf_wn, rf_d, busy
   );

   modport slave (
      input  a_req, a_wn, a_d,
      input  b_req, b_wn, b_d,
      input  rsv_req, rsv_wn,
      output a_gnt, b_gnt,
      output rf_we, rf_wn, rf_d, busy
   );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter (A pipeline vs B long-latency unit) plus busy scoreboard for pending B writes.
// Grants are combinational (0 cycles); the winning write appears on rf_we/rf_wn/rf_d one edge after the accept.
// Loser holds its request; B is aged to priority after MAX_WAIT refusals, or strict RR when REGFILE_ARB_RR_EN is defined.
module regfile_wr_arbiter #(
   parameter int unsigned MAX_WAIT = 3   // 1..15: consecutive refusals of B before B is forced to win
) (
   input logic                  clk,
   input logic                  clr,
   regfile_wr_arbiter_if.slave  bus
);

   // Grant decision and accepted-write selection
   logic        a_gnt;
   logic        b_gnt;
   logic        acc;
   logic [4:0]  win_wn;
   logic [31:0] win_d;

   // Registered write port and scoreboard
   logic        rf_we_q, rf_we_d;
   logic [4:0]  rf_wn_q, rf_wn_d;
   logic [31:0] rf_d_q,  rf_d_d;
   logic [31:0] busy_q,  busy_d;

`ifdef REGFILE_ARB_RR_EN
   // Preferred requester when both ask: 0 = A, 1 = B
   logic        ptr_q, ptr_d;
`else
   localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);
   // Consecutive cycles B has been refused while requesting
   logic [3:0]  wait_q, wait_d;
`endif

   // Pick at most one winner; depends only on req, pointer/counter and clr, never on wn/d
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (!clr) begin
`ifdef REGFILE_ARB_RR_EN
         if (bus.a_req && bus.b_req) begin
            if (ptr_q) b_gnt = 1'b1;
            else       a_gnt = 1'b1;
         end else begin
            a_gnt = bus.a_req;
            b_gnt = bus.b_req;
         end
`else
         if (bus.b_req && (wait_q >= MaxWaitC)) begin
            b_gnt = 1'b1;
         end else if (bus.a_req) begin
            a_gnt = 1'b1;
         end else if (bus.b_req) begin
            b_gnt = 1'b1;
         end
`endif
      end
   end

`ifdef REGFILE_ARB_RR_EN
   // Pointer flips to the other requester after every grant
   always_comb begin
      ptr_d = ptr_q;
      if (a_gnt)      ptr_d = 1'b1;
      else if (b_gnt) ptr_d = 1'b0;
   end
`else
   // Age B while it is refused; any grant or a dropped request restarts the count
   always_comb begin
      wait_d = 4'd0;
      if (bus.b_req && !b_gnt) begin
         wait_d = (wait_q == 4'hF) ? wait_q : wait_q + 4'd1;
      end
   end
`endif

   // Route the winner to the write port; r0 writes are consumed but not written
   always_comb begin
      acc     = a_gnt | b_gnt;
      win_wn  = b_gnt ? bus.b_wn : bus.a_wn;
      win_d   = b_gnt ? bus.b_d  : bus.a_d;
      rf_we_d = acc && (win_wn != 5'd0);
      rf_wn_d = acc ? win_wn : rf_wn_q;
      rf_d_d  = acc ? win_d  : rf_d_q;
   end

   // Scoreboard: retire on B accept, then apply reservation so a same-register reserve wins
   always_comb begin
      busy_d = busy_q;
      if (b_gnt) begin
         busy_d[bus.b_wn] = 1'b0;
      end
      if (bus.rsv_req && (bus.rsv_wn != 5'd0)) begin
         busy_d[bus.rsv_wn] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // All state, with synchronous clear back to idle / A-preferred
   always_ff @(posedge clk) begin
      if (clr) begin
         rf_we_q <= 1'b0;
         rf_wn_q <= 5'd0;
         rf_d_q  <= 32'd0;
         busy_q  <= 32'd0;
`ifdef REGFILE_ARB_RR_EN
         ptr_q   <= 1'b0;
`else
         wait_q  <= 4'd0;
`endif
      end else begin
         rf_we_q <= rf_we_d;
         rf_wn_q <= rf_wn_d;
         rf_d_q  <= rf_d_d;
         busy_q  <= busy_d;
`ifdef REGFILE_ARB_RR_EN
         ptr_q   <= ptr_d;
`else
         wait_q  <= wait_d;
`endif
      end
   end

   assign bus.a_gnt = a_gnt;
   assign bus.b_gnt = b_gnt;
   assign bus.rf_we = rf_we_q;
   assign bus.rf_wn = rf_wn_q;
   assign bus.rf_d  = rf_d_q;
   assign bus.busy  = busy_q;

   // Protocol invariants: single grant, grants only to requesters, r0 never busy
   a_one_grant : assert property (@(posedge clk) !(a_gnt && b_gnt));
   a_a_req     : assert property (@(posedge clk) a_gnt |-> bus.a_req);
   a_b_req     : assert property (@(posedge clk) b_gnt |-> bus.b_req);
   a_r0_free   : assert property (@(posedge clk) disable iff (clr) !busy_q[0]);
`ifndef REGFILE_ARB_RR_EN
   // The counter can never pass the bound because B wins once it gets there
   a_wait_bnd  : assert property (@(posedge clk) disable iff (clr) wait_q <= MaxWaitC);
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed vector bench for regfile_wr_arbiter (MAX_WAIT=3); expectations follow REGFILE_ARB_RR_EN if defined.
// Each vector: drive at negedge, check grants 1ns later, check write port and busy 1ns after the next posedge.
// Hand-written tail: long contention run bounding B's consecutive refusals.
module tb_regfile_wr_arbiter;

   localparam logic [31:0] AD = 32'hA1A1_A1A1;
   localparam logic [31:0] BD = 32'hB2B2_B2B2;

   logic clk;
   logic clr;
   int   n_cmp;
   int   n_bad;

   regfile_wr_arbiter_if bus ();

   regfile_wr_arbiter #(.MAX_WAIT(3)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        clr;
      logic        a_req;
      logic [4:0]  a_wn;
      logic [31:0] a_d;
      logic        b_req;
      logic [4:0]  b_wn;
      logic [31:0] b_d;
      logic        rsv_req;
      logic [4:0]  rsv_wn;
      logic        e_a_gnt;
      logic        e_b_gnt;
      logic        e_we;
      logic [4:0]  e_wn;
      logic [31:0] e_d;
      logic [31:0] e_busy;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(string nm, logic c,
                               logic ar, logic [4:0] awn, logic [31:0] ad,
                               logic br, logic [4:0] bwn, logic [31:0] bd,
                               logic rr, logic [4:0] rwn,
                               logic ea, logic eb, logic ewe, logic [4:0] ewn,
                               logic [31:0] ed, logic [31:0] ebusy);
      vec_t v;
      v.name = nm; v.clr = c;
      v.a_req = ar; v.a_wn = awn; v.a_d = ad;
      v.b_req = br; v.b_wn = bwn; v.b_d = bd;
      v.rsv_req = rr; v.rsv_wn = rwn;
      v.e_a_gnt = ea; v.e_b_gnt = eb;
      v.e_we = ewe; v.e_wn = ewn; v.e_d = ed; v.e_busy = ebusy;
      return v;
   endfunction

   // Both requesters asking: A writes r1/AD, B writes r2/BD; g names the expected winner
   function automatic vec_t both(string nm, byte g, logic [31:0] ebusy);
      logic ga;
      ga = (g == "A");
      return mk(nm, 1'b0, 1'b1, 5'd1, AD, 1'b1, 5'd2, BD, 1'b0, 5'd0,
                ga, !ga, 1'b1, ga ? 5'd1 : 5'd2, ga ? AD : BD, ebusy);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h, want %08h", nm, act, exp);
      end
   endtask

   task automatic apply(vec_t v);
      @(negedge clk);
      clr         = v.clr;
      bus.a_req   = v.a_req;
      bus.a_wn    = v.a_wn;
      bus.a_d     = v.a_d;
      bus.b_req   = v.b_req;
      bus.b_wn    = v.b_wn;
      bus.b_d     = v.b_d;
      bus.rsv_req = v.rsv_req;
      bus.rsv_wn  = v.rsv_wn;
      #1;
      chk({v.name, ".a_gnt"}, 32'(bus.a_gnt), 32'(v.e_a_gnt));
      chk({v.name, ".b_gnt"}, 32'(bus.b_gnt), 32'(v.e_b_gnt));
      @(posedge clk);
      #1;
      chk({v.name, ".rf_we"}, 32'(bus.rf_we), 32'(v.e_we));
      chk({v.name, ".rf_wn"}, 32'(bus.rf_wn), 32'(v.e_wn));
      chk({v.name, ".rf_d"},  bus.rf_d,        v.e_d);
      chk({v.name, ".busy"},  bus.busy,        v.e_busy);
   endtask

   initial begin
      string pat_pre;
      string pat_post;
      int    run;
      int    max_run;
      int    b_wins;
      int    dbl;
      int    exp_run;
      int    exp_bw;

`ifdef REGFILE_ARB_RR_EN
      string pat = "ABABABAB";
      pat_pre  = "AB";
      pat_post = "ABAB";
      exp_run  = 1;
      exp_bw   = 10;
`else
      string pat = "AAABAAAB";
      pat_pre  = "AA";
      pat_post = "AAAB";
      exp_run  = 3;
      exp_bw   = 5;
`endif

      clk = 1'b0; clr = 1'b1;
      n_cmp = 0; n_bad = 0;
      bus.a_req = 1'b0; bus.a_wn = '0; bus.a_d = '0;
      bus.b_req = 1'b0; bus.b_wn = '0; bus.b_d = '0;
      bus.rsv_req = 1'b0; bus.rsv_wn = '0;

      // Reset with both requests present, then single writes
      //                 name        clr  a: req wn     d             b: req wn     d            rsv   wn      ga  gb  we  wn     d              busy
      tv.push_back(mk("rst0",     1, 1, 5'd3, 32'hAAAA0003, 1, 5'd4, 32'hBBBB0004, 0, 5'd0,  0, 0, 0, 5'd0, 32'h0,         32'h0));
      tv.push_back(mk("rst1",     1, 1, 5'd3, 32'hAAAA0003, 1, 5'd4, 32'hBBBB0004, 0, 5'd0,  0, 0, 0, 5'd0, 32'h0,         32'h0));
      tv.push_back(mk("a_r5",     0, 1, 5'd5, 32'h12345678, 0, 5'd0, 32'h0,        0, 5'd0,  1, 0, 1, 5'd5, 32'h12345678,  32'h0));
      tv.push_back(mk("a_r0",     0, 1, 5'd0, 32'hDEADBEEF, 0, 5'd0, 32'h0,        0, 5'd0,  1, 0, 0, 5'd0, 32'hDEADBEEF,  32'h0));
      tv.push_back(mk("idle",     0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0,  0, 0, 0, 5'd0, 32'hDEADBEEF,  32'h0));
      // Scoreboard
      tv.push_back(mk("rsv7",     0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd7,  0, 0, 0, 5'd0, 32'hDEADBEEF,  32'h80));
      tv.push_back(mk("b_r7",     0, 0, 5'd0, 32'h0,        1, 5'd7, 32'h77,       0, 5'd0,  0, 1, 1, 5'd7, 32'h77,        32'h0));
      tv.push_back(mk("rsv9",     0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd9,  0, 0, 0, 5'd7, 32'h77,        32'h200));
      tv.push_back(mk("rsv9_b9",  0, 0, 5'd0, 32'h0,        1, 5'd9, 32'h99,       1, 5'd9,  0, 1, 1, 5'd9, 32'h99,        32'h200));
      tv.push_back(mk("rsv0",     0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd0,  0, 0, 0, 5'd9, 32'h99,        32'h200));
      tv.push_back(mk("rsv3_b9",  0, 0, 5'd0, 32'h0,        1, 5'd9, 32'h9A,       1, 5'd3,  0, 1, 1, 5'd9, 32'h9A,        32'h8));
      tv.push_back(mk("rsv3_rep", 0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd3,  0, 0, 0, 5'd9, 32'h9A,        32'h8));
      // Contention from a clean counter/pointer
      for (int i = 0; i < 8; i++) tv.push_back(both($sformatf("cont%0d", i), pat[i], 32'h8));
      for (int i = 0; i < 3; i++)
         tv.push_back(mk($sformatf("a_only%0d", i), 0, 1, 5'd1, AD, 0, 5'd0, 32'h0, 0, 5'd0, 1, 0, 1, 5'd1, AD, 32'h8));
      // Build busy = 0x0F00 (clear r3 and set r8 together), then B waits two cycles
      tv.push_back(mk("b3_rsv8",  0, 0, 5'd0, 32'h0,        1, 5'd3, 32'h33,       1, 5'd8,  0, 1, 1, 5'd3, 32'h33,        32'h100));
      tv.push_back(mk("rsv9b",    0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd9,  0, 0, 0, 5'd3, 32'h33,        32'h300));
      tv.push_back(mk("rsv10",    0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd10, 0, 0, 0, 5'd3, 32'h33,        32'h700));
      tv.push_back(mk("rsv11",    0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd11, 0, 0, 0, 5'd3, 32'h33,        32'hF00));
      for (int i = 0; i < 2; i++) tv.push_back(both($sformatf("pre%0d", i), pat_pre[i], 32'hF00));
      // Mid-operation clear with both requests asserted; counter must restart from zero afterwards
      tv.push_back(mk("clr_mid",  1, 1, 5'd1, AD,           1, 5'd2, BD,           0, 5'd0,  0, 0, 0, 5'd0, 32'h0,         32'h0));
      for (int i = 0; i < 4; i++) tv.push_back(both($sformatf("post%0d", i), pat_post[i], 32'h0));
      tv.push_back(mk("idle_end", 0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0,  0, 0, 0, 5'd2, BD,            32'h0));

      foreach (tv[i]) apply(tv[i]);

      // Long contention: B's consecutive refusals stay within the bound, never two grants at once
      run = 0; max_run = 0; b_wins = 0; dbl = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.a_req = 1'b1; bus.a_wn = 5'd1; bus.a_d = AD;
         bus.b_req = 1'b1; bus.b_wn = 5'd2; bus.b_d = BD;
         #1;
         if (bus.a_gnt && bus.b_gnt) dbl++;
         if (bus.b_gnt) begin
            b_wins++;
            run = 0;
         end else begin
            run++;
            if (run > max_run) max_run = run;
         end
      end
      @(negedge clk);
      bus.a_req = 1'b0; bus.b_req = 1'b0;
      chk("starve.max_refusals", 32'(max_run), 32'(exp_run));
      chk("starve.b_grants",     32'(b_wins),  32'(exp_bw));
      chk("starve.double_grant", 32'(dbl),     32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
